bist_sequencer: RTL and testbench

Built-in self-test controller for the small gate-level combinational blocks in this design. It drives every input combination onto a DUT's inputs and holds each vector for a programmable settle time. It compacts the DUT's outputs into a MISR signature and compares the final signature against a golden value. It sits beside the combinational block it tests and owns that block's inputs whenever it is busy.

---
 rtl/bist_pkg.sv | 13 +
 rtl/bist_misr.sv | 39 +++
 rtl/bist_sequencer.sv | 109 ++++++++++
 tb/tb_bist_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: FSM state encoding and default MISR polynomial.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_t;

  localparam logic [7:0] DEFAULT_POLY = 8'h1D;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: Galois-style shift with polynomial feedback, XORing in
// the DUT outputs on each enabled edge. Exposes the next value so the caller can compare early.
module bist_misr
  import bist_pkg::*;
#(
  parameter int              SIGW = 8,
  parameter int              NOUT = 2,
  parameter logic [SIGW-1:0] POLY = DEFAULT_POLY
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [NOUT-1:0] data,
  output logic [SIGW-1:0] signature,
  output logic [SIGW-1:0] next_sig
);

  logic [SIGW-1:0] shifted;
  logic [SIGW-1:0] feedback;

  always_comb begin
    shifted  = {signature[SIGW-2:0], 1'b0};
    feedback = signature[SIGW-1] ? POLY : '0;
    next_sig = shifted ^ feedback ^ SIGW'(data);
  end

  // Clear has priority so a new run always starts from a zero signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= next_sig;
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// Exhaustive-pattern BIST controller: walks every input vector through a combinational block,
// holds each for SETTLE cycles, compacts the outputs into a MISR and checks against golden.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int              NIN    = 3,
  parameter int              NOUT   = 2,
  parameter int              SETTLE = 2,
  parameter int              SIGW   = 8,
  parameter logic [SIGW-1:0] POLY   = DEFAULT_POLY
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIGW-1:0] golden,
  input  logic [NOUT-1:0] dut_out,
  output logic [NIN-1:0]  dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [SIGW-1:0] signature
);

  localparam int CNTW = NIN + 1;
  localparam int SCW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNTW-1:0] LAST_VEC      = CNTW'((1 << NIN) - 1);
  localparam logic [SCW-1:0]  SETTLE_RELOAD = SCW'(SETTLE - 1);

  bist_state_t     state;
  logic [CNTW-1:0] vec_cnt;
  logic [CNTW-1:0] next_cnt;
  logic [SCW-1:0]  settle_cnt;
  logic            misr_clear;
  logic            misr_enable;
  logic [SIGW-1:0] misr_next;

  assign next_cnt    = vec_cnt + CNTW'(1);
  assign misr_clear  = (state == ST_IDLE) && start;
  assign misr_enable = (state == ST_CAPTURE);

  bist_misr #(
    .SIGW (SIGW),
    .NOUT (NOUT),
    .POLY (POLY)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (misr_clear),
    .enable    (misr_enable),
    .data      (dut_out),
    .signature (signature),
    .next_sig  (misr_next)
  );

  // busy and done are registered alongside the state so they track it with no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec_cnt    <= '0;
      settle_cnt <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SETTLE;
            vec_cnt    <= '0;
            dut_in     <= '0;
            settle_cnt <= SETTLE_RELOAD;
            busy       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - SCW'(1);
          end
        end
        ST_CAPTURE: begin
          // The MISR updates on this same edge, so compare its next value rather than its current one.
          if (vec_cnt == LAST_VEC) begin
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (misr_next == golden);
          end else begin
            state      <= ST_SETTLE;
            vec_cnt    <= next_cnt;
            dut_in     <= next_cnt[NIN-1:0];
            settle_cnt <= SETTLE_RELOAD;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer with default parameters; expected signatures are hand-derived.
module tb_bist_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] golden;
  logic [1:0] dut_out;
  logic [2:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;
  logic       walk;

  int checks = 0;
  int errors = 0;

  bist_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .golden    (golden),
    .dut_out   (dut_out),
    .dut_in    (dut_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  // Stand-in for the block under test: identity on the low bits, or a constant for the feedback run.
  assign dut_out = walk ? dut_in[1:0] : 2'b11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dut_in"}, 32'(dut_in), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'd0);
    check({tag, " signature"}, 32'(signature), 32'd0);
  endtask

  // One full run from a start pulse; sigs holds the signature after capture i in byte i.
  task automatic run_vectors(input string name, input logic [7:0] gold, input logic [63:0] sigs,
                             input logic exp_pass, input bit poke);
    int ndone;
    ndone  = 0;
    golden = gold;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s e0 dut_in", name), 32'(dut_in), 32'd0);
    check($sformatf("%s e0 busy", name), 32'(busy), 32'd1);
    check($sformatf("%s e0 signature", name), 32'(signature), 32'd0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (done) ndone++;
      if (poke) start = (k == 4 || k == 11);
      if (k < 24) begin
        check($sformatf("%s e%0d dut_in", name, k), 32'(dut_in), 32'(k / 3));
        check($sformatf("%s e%0d done", name, k), 32'(done), 32'd0);
        check($sformatf("%s e%0d busy", name, k), 32'(busy), 32'd1);
      end
      if (k % 3 == 0)
        check($sformatf("%s e%0d signature", name, k), 32'(signature), 32'(sigs[8*(k/3-1) +: 8]));
    end
    check($sformatf("%s e24 done", name), 32'(done), 32'd1);
    check($sformatf("%s e24 pass", name), 32'(pass), 32'(exp_pass));
    tick();
    if (done) ndone++;
    check($sformatf("%s e25 busy", name), 32'(busy), 32'd0);
    check($sformatf("%s e25 done", name), 32'(done), 32'd0);
    check($sformatf("%s e25 pass", name), 32'(pass), 32'(exp_pass));
    check($sformatf("%s done count", name), 32'(ndone), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    golden = 8'h00;
    walk   = 1'b1;

    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle %0d busy", i), 32'(busy), 32'd0);
      check($sformatf("idle %0d dut_in", i), 32'(dut_in), 32'd0);
    end

    walk = 1'b1;
    run_vectors("walk", 8'h33, 64'h33_18_0D_06_03_00_01_00, 1'b1, 1'b0);

    walk = 1'b0;
    run_vectors("fb_good", 8'h1C, 64'h1C_81_41_21_11_09_05_03, 1'b1, 1'b0);
    run_vectors("fb_bad_poke", 8'h1D, 64'h1C_81_41_21_11_09_05_03, 1'b0, 1'b1);

    walk = 1'b1;
    run_vectors("walk2", 8'h33, 64'h33_18_0D_06_03_00_01_00, 1'b1, 1'b0);

    golden = 8'h33;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    check("midrun e10 dut_in", 32'(dut_in), 32'd3);
    check("midrun e10 busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero("midrun reset");
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("midrun hold %0d done", i), 32'(done), 32'd0);
      check($sformatf("midrun hold %0d busy", i), 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    run_vectors("after_reset", 8'h33, 64'h33_18_0D_06_03_00_01_00, 1'b1, 1'b0);

    golden = 8'h33;
    start  = 1'b1;
    for (int k = 0; k <= 24; k++) tick();
    check("b2b e24 done", 32'(done), 32'd1);
    check("b2b e24 pass", 32'(pass), 32'd1);
    tick();
    check("b2b e25 busy", 32'(busy), 32'd0);
    check("b2b e25 pass", 32'(pass), 32'd1);
    tick();
    check("b2b e26 busy", 32'(busy), 32'd1);
    check("b2b e26 dut_in", 32'(dut_in), 32'd0);
    check("b2b e26 signature", 32'(signature), 32'd0);
    check("b2b e26 pass", 32'(pass), 32'd1);
    start  = 1'b0;
    golden = 8'h00;
    for (int k = 27; k <= 49; k++) tick();
    check("b2b e49 done", 32'(done), 32'd0);
    check("b2b e49 pass", 32'(pass), 32'd1);
    tick();
    check("b2b e50 done", 32'(done), 32'd1);
    check("b2b e50 pass", 32'(pass), 32'd0);
    check("b2b e50 signature", 32'(signature), 32'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
